// File: rtl/win_sequencer_pkg.sv
// Shared encodings for the win overlay sequencer: FSM states, board indices, score helper.
package win_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_PLAY       = 3'd0,
    ST_ANNOUNCE   = 3'd1,
    ST_WAIT_KEY   = 3'd2,
    ST_RESTART    = 3'd3,
    ST_WAIT_CLEAR = 3'd4
  } state_t;

  typedef logic [2:0] board_t;
  typedef logic [3:0] score_t;

  localparam board_t BOARD_R_WIN_DEF = 3'd1;
  localparam board_t BOARD_L_WIN_DEF = 3'd5;
  localparam board_t BOARD_START_DEF = 3'd3;
  localparam score_t SCORE_MAX       = 4'd15;

  // Win tally stops at the top of its range instead of wrapping back to zero.
  function automatic score_t sat_inc(input score_t v);
    return (v == SCORE_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/win_sequencer_if.sv
// Game-logic / overlay-facing signal bundle of the win sequencer.
interface win_sequencer_if
  import win_sequencer_pkg::*;
  ();
  logic   vsync_in;
  board_t board_in;
  logic   continue_btn;
  logic   match_clear;
  logic   win_active;
  logic   winner;
  logic   sign_visible;
  logic   crown_visible;
  logic   round_restart;
  score_t score_l;
  score_t score_r;

  modport master (
    output vsync_in, board_in, continue_btn, match_clear,
    input  win_active, winner, sign_visible, crown_visible, round_restart, score_l, score_r
  );

  modport slave (
    input  vsync_in, board_in, continue_btn, match_clear,
    output win_active, winner, sign_visible, crown_visible, round_restart, score_l, score_r
  );
endinterface

// File: rtl/win_sequencer_vsync_edge.sv
// Frame tick generator: one-clk pulse one clk after each vsync rising edge.
module vsync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_vsync,
  output logic o_tick
);
  logic r_vs_q;
  logic r_vs_qq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_q  <= 1'b0;
      r_vs_qq <= 1'b0;
    end else begin
      r_vs_q  <= i_vsync;
      r_vs_qq <= r_vs_q;
    end
  end

  assign o_tick = r_vs_q & ~r_vs_qq;
endmodule

// File: rtl/win_sequencer.sv
// Round-end controller: declares the winner, blinks the WIN sign, tallies scores,
// then restarts the round on continue or timeout and re-arms once the board is fresh.
module win_sequencer
  import win_sequencer_pkg::*;
#(
  parameter board_t BOARD_R_WIN     = BOARD_R_WIN_DEF,
  parameter board_t BOARD_L_WIN     = BOARD_L_WIN_DEF,
  parameter board_t BOARD_START     = BOARD_START_DEF,
  parameter int     ANNOUNCE_FRAMES = 120,
  parameter int     BLINK_FRAMES    = 15,
  parameter int     TIMEOUT_FRAMES  = 600,
  parameter int     CNT_W           = 10
) (
  input  logic            clk,
  input  logic            reset,
  win_sequencer_if.slave  bus
);
  localparam logic [CNT_W-1:0] ANN_LAST   = CNT_W'(ANNOUNCE_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_frame_cnt, w_frame_nxt;
  logic [CNT_W-1:0] r_blink_cnt, w_blink_nxt;
  logic             r_win_active, w_win_active_nxt;
  logic             r_winner, w_winner_nxt;
  logic             r_sign, w_sign_nxt;
  logic             r_crown, w_crown_nxt;
  logic             r_restart, w_restart_nxt;
  score_t           r_score_l, w_score_l_nxt;
  score_t           r_score_r, w_score_r_nxt;
  logic             r_btn_q;
  logic             w_tick;
  logic             w_btn_rise;
  logic             w_win_r;
  logic             w_win_l;

  vsync_edge u_vsync_edge (
    .clk     (clk),
    .reset   (reset),
    .i_vsync (bus.vsync_in),
    .o_tick  (w_tick)
  );

  assign w_btn_rise = bus.continue_btn & ~r_btn_q;
  assign w_win_r    = (bus.board_in == BOARD_R_WIN);
  assign w_win_l    = (bus.board_in == BOARD_L_WIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_PLAY;
      r_frame_cnt  <= '0;
      r_blink_cnt  <= '0;
      r_win_active <= 1'b0;
      r_winner     <= 1'b0;
      r_sign       <= 1'b0;
      r_crown      <= 1'b0;
      r_restart    <= 1'b0;
      r_score_l    <= '0;
      r_score_r    <= '0;
      r_btn_q      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_cnt  <= w_frame_nxt;
      r_blink_cnt  <= w_blink_nxt;
      r_win_active <= w_win_active_nxt;
      r_winner     <= w_winner_nxt;
      r_sign       <= w_sign_nxt;
      r_crown      <= w_crown_nxt;
      r_restart    <= w_restart_nxt;
      r_score_l    <= w_score_l_nxt;
      r_score_r    <= w_score_r_nxt;
      r_btn_q      <= bus.continue_btn;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_frame_nxt      = r_frame_cnt;
    w_blink_nxt      = r_blink_cnt;
    w_win_active_nxt = r_win_active;
    w_winner_nxt     = r_winner;
    w_sign_nxt       = r_sign;
    w_crown_nxt      = r_crown;
    w_restart_nxt    = 1'b0;
    w_score_l_nxt    = r_score_l;
    w_score_r_nxt    = r_score_r;

    unique case (r_state)
      ST_PLAY: begin
        if (w_tick && (w_win_r || w_win_l)) begin
          w_state_nxt      = ST_ANNOUNCE;
          w_winner_nxt     = w_win_r;
          w_win_active_nxt = 1'b1;
          w_sign_nxt       = 1'b1;
          w_crown_nxt      = 1'b1;
          w_frame_nxt      = '0;
          w_blink_nxt      = '0;
          if (w_win_r) w_score_r_nxt = sat_inc(r_score_r);
          else         w_score_l_nxt = sat_inc(r_score_l);
        end
      end
      ST_ANNOUNCE: begin
        if (w_tick) begin
          // End of the announcement overrides the blink phase: sign is left on.
          if (r_frame_cnt == ANN_LAST) begin
            w_state_nxt = ST_WAIT_KEY;
            w_sign_nxt  = 1'b1;
            w_frame_nxt = '0;
            w_blink_nxt = '0;
          end else begin
            w_frame_nxt = r_frame_cnt + CNT_ONE;
            if (r_blink_cnt == BLINK_LAST) begin
              w_sign_nxt  = ~r_sign;
              w_blink_nxt = '0;
            end else begin
              w_blink_nxt = r_blink_cnt + CNT_ONE;
            end
          end
        end
      end
      ST_WAIT_KEY: begin
        if (w_btn_rise || (w_tick && (r_frame_cnt == TO_LAST))) begin
          w_state_nxt      = ST_RESTART;
          w_restart_nxt    = 1'b1;
          w_win_active_nxt = 1'b0;
          w_sign_nxt       = 1'b0;
          w_crown_nxt      = 1'b0;
          w_frame_nxt      = '0;
        end else if (w_tick) begin
          w_frame_nxt = r_frame_cnt + CNT_ONE;
        end
      end
      ST_RESTART: begin
        w_state_nxt = ST_WAIT_CLEAR;
      end
      ST_WAIT_CLEAR: begin
        // Holding here until the board is fresh keeps the stale winning board from re-triggering.
        if (bus.board_in == BOARD_START) w_state_nxt = ST_PLAY;
      end
      default: begin
        w_state_nxt = ST_PLAY;
      end
    endcase

    if (bus.match_clear) begin
      w_score_l_nxt = '0;
      w_score_r_nxt = '0;
    end
  end

  assign bus.win_active    = r_win_active;
  assign bus.winner        = r_winner;
  assign bus.sign_visible  = r_sign;
  assign bus.crown_visible = r_crown;
  assign bus.round_restart = r_restart;
  assign bus.score_l       = r_score_l;
  assign bus.score_r       = r_score_r;
endmodule

// File: tb/tb_win_sequencer.sv
// Scoreboard bench for win_sequencer: every output change is matched, in order, against
// an expected {frame, outputs} entry queued by the stimulus.
module tb_win_sequencer;
  import win_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  win_sequencer_if bus ();

  win_sequencer #(
    .ANNOUNCE_FRAMES (8),
    .BLINK_FRAMES    (2),
    .TIMEOUT_FRAMES  (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    int          frame;
    logic [12:0] vec;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          vs_cnt = 0;
  logic [3:0]  es_l = 4'd0;
  logic [3:0]  es_r = 4'd0;

  // {win_active, winner, sign, crown, restart, score_l, score_r}
  function automatic logic [12:0] obs();
    return {bus.win_active, bus.winner, bus.sign_visible, bus.crown_visible,
            bus.round_restart, bus.score_l, bus.score_r};
  endfunction

  task automatic push(input int f, input logic wa, input logic w, input logic sv,
                      input logic cv, input logic rr);
    exp_t e;
    e.frame = f;
    e.vec   = {wa, w, sv, cv, rr, es_l, es_r};
    q.push_back(e);
  endtask

  // vsync: 20 clk period, high for 2 clk; vs_cnt counts rising edges
  initial begin
    bus.vsync_in = 1'b0;
    forever begin
      repeat (18) @(negedge clk);
      bus.vsync_in = 1'b1;
      vs_cnt++;
      repeat (2) @(negedge clk);
      bus.vsync_in = 1'b0;
    end
  end

  // monitor
  initial begin
    logic [12:0] prev;
    logic [12:0] cur;
    int          rr_run;
    exp_t        e;
    prev   = '0;
    rr_run = 0;
    forever begin
      @(negedge clk);
      #2;
      cur = obs();
      if (cur[8] === 1'b1) begin
        rr_run++;
      end else if (rr_run != 0) begin
        checks++;
        if (rr_run != 1) begin
          errors++;
          $display("FAIL restart_width got %0d clk want 1", rr_run);
        end
        rr_run = 0;
      end
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change frame %0d got %b want no change", vs_cnt, cur);
        end else begin
          e = q.pop_front();
          if (cur !== e.vec || vs_cnt != e.frame) begin
            errors++;
            $display("FAIL out_change got frame %0d %b want frame %0d %b",
                     vs_cnt, cur, e.frame, e.vec);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic wait_frame(input int n);
    int guard;
    guard = 0;
    while (vs_cnt < n && guard < 2000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (vs_cnt < n) begin
      checks++;
      errors++;
      $display("FAIL wait_frame got frame %0d want %0d", vs_cnt, n);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input bit chk);
    bus.continue_btn = 1'b1;
    @(negedge clk);
    #1;
    if (chk) begin
      checks++;
      if (bus.round_restart !== 1'b1) begin
        errors++;
        $display("FAIL restart_latency got %b want 1", bus.round_restart);
      end
    end
    @(negedge clk);
    bus.continue_btn = 1'b0;
    @(negedge clk);
  endtask

  // One full win round: entry, four blink changes, then button or timeout restart.
  task automatic do_round(input bit right, input bit use_btn, input bit ann_press,
                          input bit stale, input bit clr);
    int f;
    int g;
    bus.board_in = right ? 3'd1 : 3'd5;
    f = vs_cnt + 1;
    if (clr) begin
      es_l = 4'd0;
      es_r = 4'd0;
    end else if (right) begin
      es_r = (es_r == 4'd15) ? es_r : es_r + 4'd1;
    end else begin
      es_l = (es_l == 4'd15) ? es_l : es_l + 4'd1;
    end
    push(f, 1'b1, right, 1'b1, 1'b1, 1'b0);
    if (clr) begin
      g = 0;
      while (vs_cnt < f && g < 100) begin
        @(negedge clk);
        #1;
        g++;
      end
      @(negedge clk);
      bus.match_clear = 1'b1;
      @(negedge clk);
      bus.match_clear = 1'b0;
    end
    for (int k = 1; k <= 4; k++)
      push(f + 2 * k, 1'b1, right, (k % 2 == 0), 1'b1, 1'b0);
    wait_frame(f + 1);
    if (!stale) bus.board_in = 3'd3;
    if (ann_press) press(1'b0);
    if (use_btn) begin
      wait_frame(f + 9);
      push(f + 9, 1'b0, right, 1'b0, 1'b0, 1'b1);
      push(f + 9, 1'b0, right, 1'b0, 1'b0, 1'b0);
      press(1'b1);
    end else begin
      push(f + 14, 1'b0, right, 1'b0, 1'b0, 1'b1);
      push(f + 14, 1'b0, right, 1'b0, 1'b0, 1'b0);
      wait_frame(f + 14);
    end
    if (stale) begin
      wait_frame(vs_cnt + 3);
      bus.board_in = 3'd3;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int f;
    reset            = 1'b1;
    bus.board_in     = 3'd3;
    bus.continue_btn = 1'b0;
    bus.match_clear  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (obs() !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got %b want %b", obs(), 13'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // non-win boards in PLAY do nothing
    bus.board_in = 3'd2;
    wait_frame(vs_cnt + 2);
    bus.board_in = 3'd7;
    wait_frame(vs_cnt + 1);
    bus.board_in = 3'd3;

    // right win, timeout restart, stale board held in WAIT_CLEAR
    do_round(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    // left win, press ignored in ANNOUNCE, press in WAIT_KEY
    do_round(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // saturation of score_r
    for (int i = 0; i < 16; i++) do_round(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // match_clear coinciding with the increment
    do_round(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // reset in ANNOUNCE
    bus.board_in = 3'd1;
    f = vs_cnt + 1;
    es_r = (es_r == 4'd15) ? es_r : es_r + 4'd1;
    push(f, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push(f + 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_frame(f + 3);
    es_l = 4'd0;
    es_r = 4'd0;
    push(vs_cnt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    do_round(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    wait_frame(vs_cnt + 3);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_expect got %0d entries want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
